fp_mul_seq: RTL and testbench

Sequential FP32 (IEEE-754 single) multiplier controller. It accepts an operand pair over a valid/ready handshake and classifies special operands. It then drives a 24-iteration shift-add mantissa multiply, normalises the 48-bit product, packs the result and holds it until the consumer accepts it. It owns the multiplier's FSM and sits between the ALU operand mux and the result writeback.

---
 rtl/fp_pkg.sv | 25 ++
 rtl/fp_mul_norm.sv | 23 ++
 rtl/fp_mul_seq.sv | 144 ++++++++++++++
 tb/tb_fp_mul_seq.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared FP32 field widths, special constants, FSM state and operand layout
// for the sequential single-precision multiplier.
package fp_pkg;
   localparam int unsigned MANT_W = 23;
   localparam int unsigned EXP_W  = 8;
   localparam int unsigned FP_W   = 32;
   localparam int unsigned SIG_W  = MANT_W + 1;
   localparam int unsigned PROD_W = 2 * SIG_W;
   localparam int unsigned SEXP_W = 10;
   localparam int unsigned CNT_W  = 5;
   localparam int unsigned BIAS   = 127;

   localparam logic [FP_W-1:0]  QNAN    = 32'h7FC0_0000;
   localparam logic [EXP_W-1:0] EXP_INF = 8'hFF;

   typedef enum logic [2:0] {
      S_IDLE, S_UNPACK, S_MULT, S_NORM, S_PACK, S_DONE
   } state_t;

   typedef struct packed {
      logic              sign;
      logic [EXP_W-1:0]  exp;
      logic [MANT_W-1:0] mant;
   } fp32_t;
endpackage

// File: rtl/fp_mul_norm.sv
// Normalises the 48-bit significand product (truncating) and adjusts the
// unbiased exponent sum by one when the product carried into bit 47.
module fp_mul_norm
   import fp_pkg::*;
(
   input  logic [PROD_W-1:0]        acc,
   input  logic signed [SEXP_W-1:0] exp_sum,
   output logic [MANT_W-1:0]        mant,
   output logic signed [SEXP_W-1:0] exp_adj
);
   // Truncated-away product bits are intentionally discarded.
   logic unused_low;
   assign unused_low = ^acc[MANT_W-1:0];

   always_comb begin
      mant    = acc[PROD_W-3:PROD_W-2-MANT_W];
      exp_adj = exp_sum;
      if (acc[PROD_W-1]) begin
         mant    = acc[PROD_W-2:PROD_W-1-MANT_W];
         exp_adj = exp_sum + SEXP_W'(1);
      end
   end
endmodule

// File: rtl/fp_mul_seq.sv
// Sequential FP32 multiplier: handshake in, special-case classify, 24-step
// shift-add significand multiply, normalise, pack and hold until accepted.
module fp_mul_seq
   import fp_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [FP_W-1:0] in_a,
   input  logic [FP_W-1:0] in_b,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [FP_W-1:0] out_result,
   output logic            out_overflow,
   output logic            out_underflow,
   output logic            out_invalid,
   output logic            busy
);
   state_t                   state;
   fp32_t                    a_r, b_r;
   logic                     sign_r;
   logic [SIG_W-1:0]         ma, mb;
   logic [PROD_W-1:0]        acc;
   logic [CNT_W-1:0]         cnt;
   logic signed [SEXP_W-1:0] exp_sum, exp_n, norm_exp;
   logic [MANT_W-1:0]        mant_n, norm_mant;
   logic                     special, spec_inv;
   logic [FP_W-1:0]          spec_res;

   // Operand classification; exponent 0 counts as zero (no denormals).
   logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
   assign a_zero = (a_r.exp == '0);
   assign b_zero = (b_r.exp == '0);
   assign a_inf  = (a_r.exp == EXP_INF) && (a_r.mant == '0);
   assign b_inf  = (b_r.exp == EXP_INF) && (b_r.mant == '0);
   assign a_nan  = (a_r.exp == EXP_INF) && (a_r.mant != '0);
   assign b_nan  = (b_r.exp == EXP_INF) && (b_r.mant != '0);

   fp_mul_norm u_norm (
      .acc     (acc),
      .exp_sum (exp_sum),
      .mant    (norm_mant),
      .exp_adj (norm_exp)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= S_IDLE;
         in_ready      <= 1'b1;
         out_valid     <= 1'b0;
         busy          <= 1'b0;
         out_result    <= '0;
         out_overflow  <= 1'b0;
         out_underflow <= 1'b0;
         out_invalid   <= 1'b0;
         a_r           <= '0;
         b_r           <= '0;
         sign_r        <= 1'b0;
         ma            <= '0;
         mb            <= '0;
         acc           <= '0;
         cnt           <= '0;
         exp_sum       <= '0;
         exp_n         <= '0;
         mant_n        <= '0;
         special       <= 1'b0;
         spec_inv      <= 1'b0;
         spec_res      <= '0;
      end else begin
         case (state)
            S_IDLE: if (in_valid && in_ready) begin
               a_r           <= in_a;
               b_r           <= in_b;
               in_ready      <= 1'b0;
               busy          <= 1'b1;
               out_overflow  <= 1'b0;
               out_underflow <= 1'b0;
               out_invalid   <= 1'b0;
               state         <= S_UNPACK;
            end
            S_UNPACK: begin
               sign_r   <= a_r.sign ^ b_r.sign;
               ma       <= {1'b1, a_r.mant};
               mb       <= {1'b1, b_r.mant};
               exp_sum  <= $signed({2'b00, a_r.exp}) + $signed({2'b00, b_r.exp})
                           - $signed(SEXP_W'(BIAS));
               acc      <= '0;
               cnt      <= '0;
               spec_inv <= 1'b0;
               special  <= 1'b1;
               if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
                  spec_res <= QNAN;
                  spec_inv <= 1'b1;
               end else if (a_inf || b_inf) begin
                  spec_res <= {a_r.sign ^ b_r.sign, EXP_INF, MANT_W'(0)};
               end else if (a_zero || b_zero) begin
                  spec_res <= {a_r.sign ^ b_r.sign, (FP_W-1)'(0)};
               end else begin
                  special <= 1'b0;
               end
               // Specials still pass through NORM so they take three edges.
               state <= (a_nan || b_nan || a_inf || b_inf || a_zero || b_zero)
                        ? S_NORM : S_MULT;
            end
            S_MULT: begin
               if (mb[cnt]) acc <= acc + (PROD_W'(ma) << cnt);
               cnt <= cnt + CNT_W'(1);
               if (cnt == CNT_W'(SIG_W - 1)) state <= S_NORM;
            end
            S_NORM: begin
               if (!special) begin
                  exp_n  <= norm_exp;
                  mant_n <= norm_mant;
               end
               state <= S_PACK;
            end
            S_PACK: begin
               if (special) begin
                  out_result  <= spec_res;
                  out_invalid <= spec_inv;
               end else if (exp_n >= $signed(SEXP_W'(255))) begin
                  out_result   <= {sign_r, EXP_INF, MANT_W'(0)};
                  out_overflow <= 1'b1;
               end else if (exp_n <= $signed(SEXP_W'(0))) begin
                  out_result    <= {sign_r, (FP_W-1)'(0)};
                  out_underflow <= 1'b1;
               end else begin
                  out_result <= {sign_r, exp_n[EXP_W-1:0], mant_n};
               end
               out_valid <= 1'b1;
               state     <= S_DONE;
            end
            S_DONE: if (out_ready) begin
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
               busy      <= 1'b0;
               state     <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_fp_mul_seq.sv
// Directed self-checking bench for fp_mul_seq: products, specials, latency,
// backpressure hold and mid-operation reset.
module tb_fp_mul_seq;
   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_a, in_b;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_result;
   logic        out_overflow, out_underflow, out_invalid;
   logic        busy;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   fp_mul_seq dut (
      .clk           (clk),
      .rst           (rst),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_a          (in_a),
      .in_b          (in_b),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_result    (out_result),
      .out_overflow  (out_overflow),
      .out_underflow (out_underflow),
      .out_invalid   (out_invalid),
      .busy          (busy)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   // Present an operand pair, count edges to out_valid, check result/flags.
   task automatic start_op(input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      in_a     = a;
      in_b     = b;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_result(input string tag, input int lat, input logic [31:0] res,
                              input logic [2:0] flags);
      int edges;
      edges = 1;
      while (!out_valid && edges < 200) begin
         @(posedge clk);
         #1;
         edges++;
      end
      // Accept edge itself was consumed by start_op, so the first loop edge is #2.
      chk({tag, "_lat"}, 32'(edges - 1), 32'(lat));
      chk({tag, "_res"}, out_result, res);
      chk({tag, "_flags"}, {29'b0, out_overflow, out_underflow, out_invalid}, {29'b0, flags});
   endtask

   task automatic release_result(input string tag);
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      chk({tag, "_rel_ready"}, {31'b0, in_ready}, 32'd1);
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_a      = '0;
      in_b      = '0;
      out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
      chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
      chk("rst_busy", {31'b0, busy}, 32'd0);
      chk("rst_result", out_result, 32'h0);
      chk("rst_flags", {29'b0, out_overflow, out_underflow, out_invalid}, 32'd0);
      rst = 1'b0;

      start_op(32'h3FC0_0000, 32'h4000_0000);
      chk("busy_after_accept", {31'b0, busy}, 32'd1);
      wait_result("mul_1p5x2", 27, 32'h4040_0000, 3'b000);
      release_result("mul_1p5x2");

      start_op(32'h4040_0000, 32'h4040_0000);
      wait_result("mul_3x3", 27, 32'h4110_0000, 3'b000);
      release_result("mul_3x3");

      start_op(32'h0000_0000, 32'hC040_0000);
      wait_result("zero_neg", 3, 32'h8000_0000, 3'b000);
      release_result("zero_neg");

      start_op(32'h7F80_0000, 32'h0000_0000);
      wait_result("inf_zero", 3, 32'h7FC0_0000, 3'b001);
      release_result("inf_zero");

      start_op(32'h7F00_0000, 32'h7F00_0000);
      wait_result("ovf", 27, 32'h7F80_0000, 3'b100);
      release_result("ovf");

      start_op(32'h0080_0000, 32'h0080_0000);
      wait_result("unf", 27, 32'h0000_0000, 3'b010);
      release_result("unf");

      // Hold in DONE with a second request pending; it must be ignored.
      start_op(32'h3FC0_0000, 32'h4000_0000);
      wait_result("hold", 27, 32'h4040_0000, 3'b000);
      @(negedge clk);
      in_a     = 32'h4040_0000;
      in_b     = 32'h4040_0000;
      in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         chk("hold_res", out_result, 32'h4040_0000);
         chk("hold_valid", {31'b0, out_valid}, 32'd1);
         chk("hold_in_ready", {31'b0, in_ready}, 32'd0);
      end
      in_valid = 1'b0;
      chk("hold_flags", {29'b0, out_overflow, out_underflow, out_invalid}, 32'd0);
      release_result("hold");
      chk("hold_valid_drop", {31'b0, out_valid}, 32'd0);
      start_op(32'h4040_0000, 32'h4040_0000);
      chk("next_accepted", {31'b0, busy}, 32'd1);
      wait_result("next_3x3", 27, 32'h4110_0000, 3'b000);
      release_result("next_3x3");

      // Reset in the middle of MULT discards the operation.
      start_op(32'h3FC0_0000, 32'h4000_0000);
      repeat (10) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk("mid_rst_in_ready", {31'b0, in_ready}, 32'd1);
      chk("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
      chk("mid_rst_busy", {31'b0, busy}, 32'd0);
      start_op(32'h3FC0_0000, 32'h4000_0000);
      wait_result("post_rst", 27, 32'h4040_0000, 3'b000);
      release_result("post_rst");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
